// File: rtl/cache_top.sv
// Two-way set-associative, write-allocate lookup cache: 4 sets, one 16-bit word per line.
// Lookup is combinational; fills come from a byte-swapped-address main-memory stand-in.
module cache_top (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] add,
    input  logic [1:0]  ad,
    input  logic        we,
    output logic        hit,
    output logic [15:0] data_out,
    output logic        uu,
    output logic        v0,
    output logic        v1
);

    localparam int SETS   = 4;
    localparam int WAYS   = 2;
    localparam int TAG_W  = 10;
    localparam int DATA_W = 16;

    logic [WAYS-1:0]   r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS];
    logic [SETS-1:0]   r_lru;

    logic [1:0]        w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit0;
    logic              w_hit1;
    logic              w_fill_way;
    logic [DATA_W-1:0] w_fill_data;

    assign w_idx       = add[5:4];
    assign w_tag       = add[15:6];
    assign w_fill_data = {add[7:0], add[15:8]};

    always_comb begin
        w_hit0   = r_valid[w_idx][0] && (r_tag[w_idx][0] == w_tag);
        w_hit1   = r_valid[w_idx][1] && (r_tag[w_idx][1] == w_tag);
        hit      = w_hit0 | w_hit1;
        data_out = '0;
        // Way 0 wins if both ways somehow hold the same tag.
        if (w_hit0) begin
            data_out = r_data[w_idx][0];
        end else if (w_hit1) begin
            data_out = r_data[w_idx][1];
        end
        uu = r_lru[w_idx];
        v0 = r_valid[w_idx][0];
        v1 = r_valid[w_idx][1];
    end

    always_comb begin
        case (ad)
            2'b01:   w_fill_way = 1'b0;
            2'b10:   w_fill_way = 1'b1;
            default: w_fill_way = r_lru[w_idx];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: tag and data arrays are cleared too, since an all-zero image after reset is part of the contract.
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_tag[s][w]  <= '0;
                    r_data[s][w] <= '0;
                end
            end
            r_lru <= '0;
        end else if (we) begin
            r_valid[w_idx][w_fill_way] <= 1'b1;
            r_tag[w_idx][w_fill_way]   <= w_tag;
            r_data[w_idx][w_fill_way]  <= w_fill_data;
            r_lru[w_idx]               <= ~w_fill_way;
        end
    end

endmodule

// File: tb/tb_cache_top.sv
// Self-checking bench for cache_top: directed scenarios plus randomized traffic
// compared against a per-set behavioural model of the cache.
module tb_cache_top;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] add = '0;
    logic [1:0]  ad  = '0;
    logic        we  = 1'b0;
    logic        hit;
    logic [15:0] data_out;
    logic        uu;
    logic        v0;
    logic        v1;

    int checks = 0;
    int errors = 0;

    cache_top dut (
        .clk      (clk),
        .rst      (rst),
        .add      (add),
        .ad       (ad),
        .we       (we),
        .hit      (hit),
        .data_out (data_out),
        .uu       (uu),
        .v0       (v0),
        .v1       (v1)
    );

    always #5 clk = ~clk;

    // Reference model: each set holds two lines and a "replace next" way number.
    typedef struct {
        bit          valid;
        bit [9:0]    tag;
        bit [15:0]   word;
    } line_t;

    line_t m_line [4][2];
    int    m_next [4];

    function automatic void model_reset();
        for (int s = 0; s < 4; s++) begin
            m_next[s] = 0;
            for (int w = 0; w < 2; w++) m_line[s][w] = '{valid: 0, tag: 0, word: 0};
        end
    endfunction

    function automatic void model_fill(input logic [15:0] a, input logic [1:0] sel);
        int set = int'(a[5:4]);
        int way = (sel == 2'b01) ? 0 : (sel == 2'b10) ? 1 : m_next[set];
        m_line[set][way] = '{valid: 1, tag: a[15:6], word: {a[7:0], a[15:8]}};
        m_next[set] = 1 - way;
    endfunction

    // Packed view {hit, data_out, uu, v0, v1} expected for address a.
    function automatic logic [19:0] model_view(input logic [15:0] a);
        int        set = int'(a[5:4]);
        bit        h   = 0;
        bit [15:0] d   = 0;
        for (int w = 1; w >= 0; w--) begin
            if (m_line[set][w].valid && m_line[set][w].tag == a[15:6]) begin
                h = 1;
                d = m_line[set][w].word;
            end
        end
        return {h, d, m_next[set] == 1, m_line[set][0].valid, m_line[set][1].valid};
    endfunction

    function automatic logic [19:0] observed();
        return {hit, data_out, uu, v0, v1};
    endfunction

    // One rising edge with the given rst/we; model follows what the edge samples.
    task automatic edge_step(input logic r, input logic w);
        rst = r;
        we  = w;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else if (w) model_fill(add, ad);
        rst = 1'b0;
        we  = 1'b0;
    endtask

    task automatic look(input logic [15:0] a);
        add = a;
        #1;
    endtask

    task automatic test_reset();
        add = 16'h2f6b;
        edge_step(1'b1, 1'b0);
        for (int s = 0; s < 4; s++) begin
            look({10'h2be, s[1:0], 4'hb});
            checks++;
            if (observed() !== 20'h0) begin
                errors++;
                $display("FAIL reset_set%0d: got %h expected %h", s, observed(), 20'h0);
            end
        end
    endtask

    task automatic test_directed();
        logic [15:0] a [11];
        logic [19:0] e [11];
        // Fill way 0 of set 2.
        look(16'h2f6b); ad = 2'b01; edge_step(1'b0, 1'b1);
        a[0] = 16'h2f6b; e[0] = {1'b1, 16'h6b2f, 1'b1, 1'b1, 1'b0};
        // Set 3 before and after a way-1 fill.
        a[1] = 16'h2f7b; e[1] = 20'h0;
        a[2] = 16'h2f7b; e[2] = {1'b1, 16'h7b2f, 1'b0, 1'b0, 1'b1};
        // Conflict in set 2.
        a[3] = 16'h2fab; e[3] = {1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        a[4] = 16'h2fab; e[4] = {1'b1, 16'hab2f, 1'b0, 1'b1, 1'b1};
        a[5] = 16'h2f6b; e[5] = {1'b1, 16'h6b2f, 1'b0, 1'b1, 1'b1};
        // LRU replacement evicts way 0.
        a[6] = 16'h2feb; e[6] = {1'b1, 16'heb2f, 1'b1, 1'b1, 1'b1};
        a[7] = 16'h2f6b; e[7] = {1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        a[8] = 16'h2fab; e[8] = {1'b1, 16'hab2f, 1'b1, 1'b1, 1'b1};
        // Low nibble does not take part in the lookup.
        a[9]  = 16'h2fa0; e[9]  = {1'b1, 16'hab2f, 1'b1, 1'b1, 1'b1};
        a[10] = 16'h2fef; e[10] = {1'b1, 16'heb2f, 1'b1, 1'b1, 1'b1};

        for (int i = 0; i < 11; i++) begin
            look(a[i]);
            checks++;
            if (observed() !== e[i]) begin
                errors++;
                $display("FAIL directed_%0d add=%h: got %h expected %h", i, a[i], observed(), e[i]);
            end
            case (i)
                1: begin ad = 2'b10; edge_step(1'b0, 1'b1); end
                3: begin ad = 2'b10; edge_step(1'b0, 1'b1); end
                5: begin look(16'h2feb); ad = 2'b11; edge_step(1'b0, 1'b1); end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_priority();
        logic [15:0] a [3] = '{16'h2f6b, 16'h2f7b, 16'h2fab};
        look(16'h2f6b);
        ad = 2'b01;
        edge_step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            look(a[i]);
            checks++;
            if (observed() !== 20'h0) begin
                errors++;
                $display("FAIL reset_priority add=%h: got %h expected %h", a[i], observed(), 20'h0);
            end
        end
    endtask

    task automatic test_back_to_back();
        look(16'h1234);
        ad  = 2'b00;
        we  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            model_fill(add, ad);
            checks++;
            if (uu !== logic'(k % 2)) begin
                errors++;
                $display("FAIL b2b_lru_fill%0d: got %b expected %b", k, uu, k % 2);
            end
            checks++;
            if (observed() !== model_view(add)) begin
                errors++;
                $display("FAIL b2b_view_fill%0d: got %h expected %h", k, observed(), model_view(add));
            end
        end
        we = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic        r;
        logic        w;
        for (int i = 0; i < 400; i++) begin
            // Small tag pool so sets see hits, conflicts and evictions.
            a = {8'h40, $urandom_range(0, 3) == 0 ? 2'b11 : 2'($urandom_range(0, 2)),
                 2'($urandom), 4'($urandom)};
            look(a);
            checks++;
            if (observed() !== model_view(a)) begin
                errors++;
                $display("FAIL random_pre_%0d add=%h: got %h expected %h", i, a, observed(), model_view(a));
            end
            ad = 2'($urandom);
            r  = ($urandom_range(0, 39) == 0);
            w  = ($urandom_range(0, 2) != 0);
            edge_step(r, w);
            checks++;
            if (observed() !== model_view(a)) begin
                errors++;
                $display("FAIL random_post_%0d add=%h rst=%b we=%b ad=%b: got %h expected %h",
                         i, a, r, w, ad, observed(), model_view(a));
            end
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_reset_priority();
        test_back_to_back();
        edge_step(1'b1, 1'b0);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
